// File: rtl/tdp_sched_pkg.sv
// ---------------------------------------------------------------------------
// tdp_sched_pkg
// Shared definitions for the two-port RAM request scheduler.
//   STALL_W : width of the anti-starvation stall counter (MAX_STALL <= 15)
//   COLL_W  : width of the saturating collision counter
//   arb_e   : per-cycle arbitration outcome of the issue stage
// The request struct depends on the instantiating module's ABITS/WIDTH and
// is therefore declared inside tdp_req_scheduler.
// ---------------------------------------------------------------------------
package tdp_sched_pkg;

    localparam int STALL_W = 4;
    localparam int COLL_W  = 16;

    typedef enum logic [1:0] {
        ARB_FREE   = 2'd0,  // no write/write collision, both heads may issue
        ARB_B_WINS = 2'd1,  // collision, B issues and A is held
        ARB_A_WINS = 2'd2   // collision after MAX_STALL stalls, A issues
    } arb_e;

endpackage

// File: rtl/tdp_skid_buf.sv
// ---------------------------------------------------------------------------
// tdp_skid_buf
// Two-entry valid/ready request buffer. in_ready is registered and equals
// "buffer not full"; it is low during reset and rises on the first clock
// after release.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake, in_data is the pushed word
//   out_valid           buffer holds at least one entry (head is valid)
//   out_pop             consume the head this cycle
//   out_data            head entry
// ---------------------------------------------------------------------------
module tdp_skid_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_pop,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [1:0]    count_nxt;
    logic          push;
    logic          pop;

    assign push      = in_valid & in_ready;
    assign pop       = out_pop & (count != 2'd0);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 2'd1;
        else if (pop && !push)
            count_nxt = count - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            count    <= count_nxt;
            // ready looks one cycle ahead so it drops right after the
            // second entry is written
            in_ready <= (count_nxt != 2'd2);
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
        end
    end

    // storage carries no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/tdp_req_scheduler.sv
// ---------------------------------------------------------------------------
// tdp_req_scheduler
// Schedules read/write requests from clients A and B onto a two-port RAM.
// Same-address write/write collisions go to B unless A has been stalled
// MAX_STALL consecutive times, in which case A goes first. Read data comes
// back one cycle after rden_* as rsp_valid_*/rsp_data_*.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid_*/req_ready_*         request handshake per client
//   req_we_*, req_addr_*, req_wdata_*  request payload
//   wren_*, rden_*, addr_*, wdata_* registered RAM pins
//   rdata_*                         RAM read data (1 cycle after rden_*)
//   rsp_valid_*, rsp_data_*         read response per client
//   collisions                      saturating write/write collision count
// ---------------------------------------------------------------------------
module tdp_req_scheduler
    import tdp_sched_pkg::*;
#(
    parameter int ABITS     = 12,
    parameter int WIDTH     = 72,
    parameter int MAX_STALL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_a,
    output logic              req_ready_a,
    input  logic              req_we_a,
    input  logic [ABITS-1:0]  req_addr_a,
    input  logic [WIDTH-1:0]  req_wdata_a,
    input  logic              req_valid_b,
    output logic              req_ready_b,
    input  logic              req_we_b,
    input  logic [ABITS-1:0]  req_addr_b,
    input  logic [WIDTH-1:0]  req_wdata_b,
    output logic              wren_a,
    output logic              rden_a,
    output logic [ABITS-1:0]  addr_a,
    output logic [WIDTH-1:0]  wdata_a,
    output logic              wren_b,
    output logic              rden_b,
    output logic [ABITS-1:0]  addr_b,
    output logic [WIDTH-1:0]  wdata_b,
    input  logic [WIDTH-1:0]  rdata_a,
    input  logic [WIDTH-1:0]  rdata_b,
    output logic              rsp_valid_a,
    output logic [WIDTH-1:0]  rsp_data_a,
    output logic              rsp_valid_b,
    output logic [WIDTH-1:0]  rsp_data_b,
    output logic [COLL_W-1:0] collisions
);

    typedef struct packed {
        logic             we;
        logic [ABITS-1:0] addr;
        logic [WIDTH-1:0] wdata;
    } req_t;

    localparam int                 REQ_W       = $bits(req_t);
    localparam logic [STALL_W-1:0] MAX_STALL_C = STALL_W'(MAX_STALL);

    function automatic logic [COLL_W-1:0] sat_inc(input logic [COLL_W-1:0] v);
        return (v == {COLL_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    req_t               in_a;
    req_t               in_b;
    req_t               head_a_p0;
    req_t               head_b_p0;
    logic               vld_a_p0;
    logic               vld_b_p0;
    logic               coll_p0;
    arb_e               arb_p0;
    logic               issue_a_p0;
    logic               issue_b_p0;
    logic [STALL_W-1:0] stall_cnt;

    assign in_a = {req_we_a, req_addr_a, req_wdata_a};
    assign in_b = {req_we_b, req_addr_b, req_wdata_b};

    tdp_skid_buf #(.DW(REQ_W)) u_buf_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (req_valid_a),
        .in_ready  (req_ready_a),
        .in_data   (in_a),
        .out_valid (vld_a_p0),
        .out_pop   (issue_a_p0),
        .out_data  (head_a_p0)
    );

    tdp_skid_buf #(.DW(REQ_W)) u_buf_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (req_valid_b),
        .in_ready  (req_ready_b),
        .in_data   (in_b),
        .out_valid (vld_b_p0),
        .out_pop   (issue_b_p0),
        .out_data  (head_b_p0)
    );

    // ---- p0: issue stage, arbitration over the two buffer heads ----
    // Only write/write to one address conflicts; every other same-address
    // mix issues both ports and leaves the outcome to the RAM.
    assign coll_p0 = vld_a_p0 && vld_b_p0 && head_a_p0.we && head_b_p0.we &&
                     (head_a_p0.addr == head_b_p0.addr);

    always_comb begin
        arb_p0 = ARB_FREE;
        if (coll_p0)
            arb_p0 = (stall_cnt == MAX_STALL_C) ? ARB_A_WINS : ARB_B_WINS;
    end

    assign issue_a_p0 = vld_a_p0 && (arb_p0 != ARB_B_WINS);
    assign issue_b_p0 = vld_b_p0 && (arb_p0 != ARB_A_WINS);

    // ---- p1: registered RAM pins, stall and collision counters ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wren_a      <= 1'b0;
            rden_a      <= 1'b0;
            addr_a      <= '0;
            wdata_a     <= '0;
            wren_b      <= 1'b0;
            rden_b      <= 1'b0;
            addr_b      <= '0;
            wdata_b     <= '0;
            stall_cnt   <= '0;
            collisions  <= '0;
            rsp_valid_a <= 1'b0;
            rsp_valid_b <= 1'b0;
        end else begin
            wren_a <= issue_a_p0 &  head_a_p0.we;
            rden_a <= issue_a_p0 & ~head_a_p0.we;
            wren_b <= issue_b_p0 &  head_b_p0.we;
            rden_b <= issue_b_p0 & ~head_b_p0.we;
            if (issue_a_p0) begin
                addr_a  <= head_a_p0.addr;
                wdata_a <= head_a_p0.wdata;
            end
            if (issue_b_p0) begin
                addr_b  <= head_b_p0.addr;
                wdata_b <= head_b_p0.wdata;
            end
            // never exceeds MAX_STALL: reaching it forces A to issue
            if (issue_a_p0)
                stall_cnt <= '0;
            else if (coll_p0)
                stall_cnt <= stall_cnt + 1'b1;
            if (coll_p0)
                collisions <= sat_inc(collisions);
            // ---- p2: response strobe, RAM read data lands this cycle ----
            rsp_valid_a <= rden_a;
            rsp_valid_b <= rden_b;
        end
    end

    assign rsp_data_a = rsp_valid_a ? rdata_a : '0;
    assign rsp_data_b = rsp_valid_b ? rdata_b : '0;

endmodule

// File: tb/tb_tdp_req_scheduler.sv
module tb_tdp_req_scheduler;

    localparam int ABITS     = 12;
    localparam int WIDTH     = 72;
    localparam int MAX_STALL = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic             req_ready_a, req_ready_b;
    logic             req_we_a = 1'b0, req_we_b = 1'b0;
    logic [ABITS-1:0] req_addr_a = '0, req_addr_b = '0;
    logic [WIDTH-1:0] req_wdata_a = '0, req_wdata_b = '0;
    logic             wren_a, rden_a, wren_b, rden_b;
    logic [ABITS-1:0] addr_a, addr_b;
    logic [WIDTH-1:0] wdata_a, wdata_b;
    logic [WIDTH-1:0] rdata_a = '0, rdata_b = '0;
    logic             rsp_valid_a, rsp_valid_b;
    logic [WIDTH-1:0] rsp_data_a, rsp_data_b;
    logic [15:0]      collisions;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] ram [0:(1<<ABITS)-1];

    tdp_req_scheduler #(.ABITS(ABITS), .WIDTH(WIDTH), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .req_we_a(req_we_a),
        .req_addr_a(req_addr_a), .req_wdata_a(req_wdata_a),
        .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .req_we_b(req_we_b),
        .req_addr_b(req_addr_b), .req_wdata_b(req_wdata_b),
        .wren_a(wren_a), .rden_a(rden_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .wren_b(wren_b), .rden_b(rden_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .rsp_valid_a(rsp_valid_a), .rsp_data_a(rsp_data_a),
        .rsp_valid_b(rsp_valid_b), .rsp_data_b(rsp_data_b),
        .collisions(collisions)
    );

    always #5 clk = ~clk;

    // Two-port RAM model: registered read, A reading while B writes sees old
    // data, B reading while A writes the same address sees wdata_a.
    initial begin
        for (int i = 0; i < (1<<ABITS); i++) ram[i] = '0;
    end

    always @(posedge clk) begin
        if (rden_a) rdata_a <= ram[addr_a];
        if (rden_b) rdata_b <= (wren_a && addr_a == addr_b) ? wdata_a : ram[addr_b];
        if (wren_a) ram[addr_a] <= wdata_a;
        if (wren_b) ram[addr_b] <= wdata_b;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    task automatic drive_a(input logic we, input logic [ABITS-1:0] ad, input logic [WIDTH-1:0] d);
        req_valid_a = 1'b1; req_we_a = we; req_addr_a = ad; req_wdata_a = d;
    endtask

    task automatic drive_b(input logic we, input logic [ABITS-1:0] ad, input logic [WIDTH-1:0] d);
        req_valid_b = 1'b1; req_we_b = we; req_addr_b = ad; req_wdata_b = d;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_a(1'b1, 12'h001, 72'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({wren_a, rden_a, wren_b, rden_b} !== 4'b0000) begin
                n_fail++; $display("FAIL reset_strobes: got %b, expected 0000", {wren_a, rden_a, wren_b, rden_b});
            end
            n_checks++;
            if ({req_ready_a, req_ready_b} !== 2'b00) begin
                n_fail++; $display("FAIL reset_ready: got %b, expected 00", {req_ready_a, req_ready_b});
            end
            n_checks++;
            if (collisions !== 16'd0) begin
                n_fail++; $display("FAIL reset_collisions: got %0d, expected 0", collisions);
            end
        end
        idle();
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({req_ready_a, req_ready_b} !== 2'b11) begin
            n_fail++; $display("FAIL ready_after_release: got %b, expected 11", {req_ready_a, req_ready_b});
        end
        n_checks++;
        if ({rsp_valid_a, rsp_valid_b, addr_a, wdata_a, addr_b, wdata_b} !== '0) begin
            n_fail++; $display("FAIL reset_pins: addr_a %0h wdata_a %0h rsp %b, expected all 0", addr_a, wdata_a, {rsp_valid_a, rsp_valid_b});
        end
    endtask

    task automatic test_independent();
        drive_a(1'b1, 12'h010, 72'hAA);
        drive_b(1'b1, 12'h020, 72'hBB);
        step();
        drive_a(1'b0, 12'h020, 72'h0);
        drive_b(1'b0, 12'h010, 72'h0);
        step();
        n_checks++;
        if ({wren_a, rden_a, addr_a, wdata_a} !== {1'b1, 1'b0, 12'h010, 72'hAA}) begin
            n_fail++; $display("FAIL indep_write_a: got we %b re %b addr %0h data %0h, expected 1 0 10 aa", wren_a, rden_a, addr_a, wdata_a);
        end
        n_checks++;
        if ({wren_b, rden_b, addr_b, wdata_b} !== {1'b1, 1'b0, 12'h020, 72'hBB}) begin
            n_fail++; $display("FAIL indep_write_b: got we %b re %b addr %0h data %0h, expected 1 0 20 bb", wren_b, rden_b, addr_b, wdata_b);
        end
        idle();
        step();
        n_checks++;
        if ({wren_a, rden_a, addr_a, wren_b, rden_b, addr_b} !== {2'b01, 12'h020, 2'b01, 12'h010}) begin
            n_fail++; $display("FAIL indep_read_issue: got a %b%b@%0h b %b%b@%0h, expected a 01@20 b 01@10", wren_a, rden_a, addr_a, wren_b, rden_b, addr_b);
        end
        n_checks++;
        if ({rsp_valid_a, rsp_valid_b} !== 2'b00) begin
            n_fail++; $display("FAIL indep_early_rsp: got %b, expected 00", {rsp_valid_a, rsp_valid_b});
        end
        step();
        n_checks++;
        if ({rsp_valid_a, rsp_data_a} !== {1'b1, 72'hBB}) begin
            n_fail++; $display("FAIL indep_rsp_a: got v %b data %0h, expected 1 bb", rsp_valid_a, rsp_data_a);
        end
        n_checks++;
        if ({rsp_valid_b, rsp_data_b} !== {1'b1, 72'hAA}) begin
            n_fail++; $display("FAIL indep_rsp_b: got v %b data %0h, expected 1 aa", rsp_valid_b, rsp_data_b);
        end
        step();
        n_checks++;
        if ({rsp_valid_a, rsp_data_a} !== {1'b0, 72'h0}) begin
            n_fail++; $display("FAIL indep_rsp_a_idle: got v %b data %0h, expected 0 0", rsp_valid_a, rsp_data_a);
        end
    endtask

    task automatic test_collision();
        drive_a(1'b1, 12'h005, 72'h1);
        drive_b(1'b1, 12'h005, 72'h2);
        step();
        idle();
        step();
        n_checks++;
        if ({wren_a, wren_b, addr_b, wdata_b} !== {1'b0, 1'b1, 12'h005, 72'h2}) begin
            n_fail++; $display("FAIL coll_first_b: got wa %b wb %b addr %0h data %0h, expected 0 1 5 2", wren_a, wren_b, addr_b, wdata_b);
        end
        n_checks++;
        if (collisions !== 16'd1) begin
            n_fail++; $display("FAIL coll_count: got %0d, expected 1", collisions);
        end
        step();
        n_checks++;
        if ({wren_a, wren_b, addr_a, wdata_a} !== {1'b1, 1'b0, 12'h005, 72'h1}) begin
            n_fail++; $display("FAIL coll_then_a: got wa %b wb %b addr %0h data %0h, expected 1 0 5 1", wren_a, wren_b, addr_a, wdata_a);
        end
        n_checks++;
        if (collisions !== 16'd1) begin
            n_fail++; $display("FAIL coll_count_hold: got %0d, expected 1", collisions);
        end
        drive_a(1'b0, 12'h005, 72'h0);
        step();
        idle();
        step();
        step();
        n_checks++;
        if ({rsp_valid_a, rsp_data_a} !== {1'b1, 72'h1}) begin
            n_fail++; $display("FAIL coll_readback: got v %b data %0h, expected 1 1", rsp_valid_a, rsp_data_a);
        end
    endtask

    task automatic test_starvation();
        logic exp_b;
        drive_a(1'b1, 12'h007, 72'hA0);
        drive_b(1'b1, 12'h007, 72'hB0);
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            exp_b = ((i % 5) != 4);
            n_checks++;
            if ({wren_a, wren_b} !== {~exp_b, exp_b}) begin
                n_fail++; $display("FAIL starve_order[%0d]: got wa %b wb %b, expected wa %b wb %b", i, wren_a, wren_b, ~exp_b, exp_b);
            end
            n_checks++;
            if (collisions !== 16'(2 + i)) begin
                n_fail++; $display("FAIL starve_count[%0d]: got %0d, expected %0d", i, collisions, 2 + i);
            end
        end
        do_reset();
    endtask

    task automatic test_mixed();
        drive_a(1'b1, 12'h003, 72'h11);
        step();
        idle();
        step();
        step();
        drive_a(1'b0, 12'h003, 72'h0);
        drive_b(1'b1, 12'h003, 72'h55);
        step();
        idle();
        step();
        n_checks++;
        if ({wren_a, rden_a, addr_a, wren_b, rden_b, addr_b} !== {2'b01, 12'h003, 2'b10, 12'h003}) begin
            n_fail++; $display("FAIL mixed_rw_issue: got a %b%b@%0h b %b%b@%0h, expected a 01@3 b 10@3", wren_a, rden_a, addr_a, wren_b, rden_b, addr_b);
        end
        step();
        n_checks++;
        if ({rsp_valid_a, rsp_data_a, rsp_valid_b} !== {1'b1, 72'h11, 1'b0}) begin
            n_fail++; $display("FAIL mixed_read_old: got v %b data %0h vb %b, expected 1 11 0", rsp_valid_a, rsp_data_a, rsp_valid_b);
        end
        n_checks++;
        if (collisions !== 16'd0) begin
            n_fail++; $display("FAIL mixed_no_coll: got %0d, expected 0", collisions);
        end
        drive_a(1'b1, 12'h003, 72'h66);
        drive_b(1'b0, 12'h003, 72'h0);
        step();
        idle();
        step();
        n_checks++;
        if ({wren_a, rden_a, wren_b, rden_b} !== 4'b1001) begin
            n_fail++; $display("FAIL mixed_wr_issue: got %b, expected 1001", {wren_a, rden_a, wren_b, rden_b});
        end
        step();
        n_checks++;
        if ({rsp_valid_b, rsp_data_b, rsp_valid_a} !== {1'b1, 72'h66, 1'b0}) begin
            n_fail++; $display("FAIL mixed_read_new: got v %b data %0h va %b, expected 1 66 0", rsp_valid_b, rsp_data_b, rsp_valid_a);
        end
    endtask

    task automatic test_backpressure_reset();
        int  cyc;
        logic seen;
        cyc  = 0;
        seen = 1'b0;
        drive_a(1'b1, 12'h009, 72'hA1);
        drive_b(1'b1, 12'h009, 72'hB1);
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            cyc++;
            if (!req_ready_a) seen = 1'b1;
        end
        n_checks++;
        if (!seen || cyc != 2) begin
            n_fail++; $display("FAIL ready_a_drop: got drop=%b after %0d cycles, expected drop after 2", seen, cyc);
        end
        idle();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wren_a, rden_a, wren_b, rden_b, req_ready_a, req_ready_b} !== 6'b0) begin
            n_fail++; $display("FAIL midreset_pins: got %b, expected 000000", {wren_a, rden_a, wren_b, rden_b, req_ready_a, req_ready_b});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({req_ready_a, req_ready_b} !== 2'b11) begin
            n_fail++; $display("FAIL midreset_ready: got %b, expected 11", {req_ready_a, req_ready_b});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({wren_a, rden_a, wren_b, rden_b, rsp_valid_a, rsp_valid_b} !== 6'b0) begin
                n_fail++; $display("FAIL midreset_drained[%0d]: got %b, expected 000000", i, {wren_a, rden_a, wren_b, rden_b, rsp_valid_a, rsp_valid_b});
            end
        end
        // the B write that was on the pins when reset hit must not have landed
        drive_a(1'b0, 12'h009, 72'h0);
        step();
        idle();
        step();
        step();
        n_checks++;
        if ({rsp_valid_a, rsp_data_a} !== {1'b1, 72'h0}) begin
            n_fail++; $display("FAIL midreset_aborted_write: got v %b data %0h, expected 1 0", rsp_valid_a, rsp_data_a);
        end
        drive_a(1'b1, 12'h009, 72'h77);
        step();
        idle();
        step();
        drive_b(1'b0, 12'h009, 72'h0);
        step();
        idle();
        step();
        step();
        n_checks++;
        if ({rsp_valid_b, rsp_data_b} !== {1'b1, 72'h77}) begin
            n_fail++; $display("FAIL resume_readback: got v %b data %0h, expected 1 77", rsp_valid_b, rsp_data_b);
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_collision();
        test_starvation();
        test_mixed();
        test_backpressure_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
